// File: rtl/complex_twiddle_mult_pipe.sv
// complex_twiddle_mult_pipe
//   Pipelined complex multiply of {real, imag} samples by the twiddle
//   W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), with round-to-nearest,
//   per-component saturation and valid/ready flow control (3-cycle latency).
//   Optional feature macro: TWIDDLE_CONJ_EN adds in_conj (multiply by conj(W)).
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_data               {real[2*DW-1:DW], imag[DW-1:0]}
//   in_k                  twiddle index
//   in_conj               (TWIDDLE_CONJ_EN only) use conjugate twiddle
//   out_valid/out_ready   output handshake
//   out_data, out_ovf     product sample and its saturation flag
module complex_twiddle_mult_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16,
  parameter int unsigned N  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*DW-1:0]      in_data,
  input  logic [$clog2(N)-1:0] in_k,
`ifdef TWIDDLE_CONJ_EN
  input  logic                 in_conj,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*DW-1:0]      out_data,
  output logic                 out_ovf
);

  localparam int unsigned KW = $clog2(N);
  localparam int unsigned QN = N / 4;
  localparam int unsigned QW = KW - 2;
  localparam int unsigned PW = DW + TW;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned RW = SW - (TW - 2);

  localparam longint PI_Q = 64'sd3373259426;  // pi * 2^30
  localparam longint ONE  = 64'sd1073741824;  // 1.0 * 2^30

  localparam logic signed [SW-1:0] RND     = SW'(1) << (TW - 3);
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  // Quarter-wave cosine entry via Taylor series in Q30, rounded to Q2.(TW-2)
  function automatic logic signed [TW-1:0] cos_entry(input int i);
    longint x, x2, term, acc;
    if (i == 0) return TW'(longint'(1) <<< (TW - 2));
    if (i == int'(QN)) return '0;
    x    = (PI_Q * 64'sd2 * longint'(i)) / longint'(N);
    x2   = (x * x) >>> 30;
    term = ONE;
    acc  = ONE;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      acc  = acc + term;
    end
    return TW'((acc + (longint'(1) <<< (30 - (TW - 2) - 1))) >>> (30 - (TW - 2)));
  endfunction

  // Clamp to DW bits; MSB of the result is the clamp flag
  function automatic logic [DW:0] sat(input logic signed [RW-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[DW-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[DW-1:0]};
    else                  return {1'b0, v[DW-1:0]};
  endfunction

  logic signed [TW-1:0] cos_tab [0:QN];
  for (genvar g = 0; g <= QN; g++) begin : g_tab
    localparam logic signed [TW-1:0] CV = cos_entry(g);
    assign cos_tab[g] = CV;
  end

  // Flow control: a stage loads when empty or when its successor loads
  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  // Twiddle lookup with quadrant folding
  logic [1:0]           q;
  logic [QW:0]          ri, rc;
  logic signed [TW-1:0] tc, ts, c_lk, s_lk;

  assign q  = in_k[KW-1 -: 2];
  assign ri = {1'b0, in_k[QW-1:0]};
  assign rc = (QW+1)'(QN) - ri;
  assign tc = cos_tab[ri];
  assign ts = cos_tab[rc];

  always_comb begin
    c_lk = tc;
    s_lk = ts;
    case (q)
      2'd0: begin c_lk =  tc; s_lk =  ts; end
      2'd1: begin c_lk = -ts; s_lk =  tc; end
      2'd2: begin c_lk = -tc; s_lk = -ts; end
      default: begin c_lk = ts; s_lk = -tc; end
    endcase
`ifdef TWIDDLE_CONJ_EN
    if (in_conj) s_lk = -s_lk;
`endif
  end

  logic signed [DW-1:0] s1_a, s1_b;
  logic signed [TW-1:0] s1_c, s1_s;
  logic signed [PW-1:0] p_ac, p_bs, p_bc, p_as;

  // S1: operand and twiddle register
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_a <= in_data[2*DW-1:DW];
      s1_b <= in_data[DW-1:0];
      s1_c <= c_lk;
      s1_s <= s_lk;
    end
  end

  // S2: full-precision products
  always_ff @(posedge clk) begin
    if (ld2 && v1) begin
      p_ac <= PW'(s1_a) * PW'(s1_c);
      p_bs <= PW'(s1_b) * PW'(s1_s);
      p_bc <= PW'(s1_b) * PW'(s1_c);
      p_as <= PW'(s1_a) * PW'(s1_s);
    end
  end

  // S3 combinational: sum, round-to-nearest, saturate
  logic signed [SW-1:0] sum_re, sum_im, rsum_re, rsum_im;
  logic signed [RW-1:0] rnd_re, rnd_im;
  logic [DW:0]          sat_re, sat_im;

  assign sum_re  = SW'(p_ac) + SW'(p_bs);
  assign sum_im  = SW'(p_bc) - SW'(p_as);
  assign rsum_re = sum_re + RND;
  assign rsum_im = sum_im + RND;
  assign rnd_re  = RW'(rsum_re >>> (TW - 2));
  assign rnd_im  = RW'(rsum_im >>> (TW - 2));
  assign sat_re  = sat(rnd_re);
  assign sat_im  = sat(rnd_im);

  logic [2*DW-1:0] data_q;
  logic            ovf_q;

  // Stage valids and output register; reset discards in-flight samples
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (ld3 && v2) begin
        data_q <= {sat_re[DW-1:0], sat_im[DW-1:0]};
        ovf_q  <= sat_re[DW] | sat_im[DW];
      end
    end
  end

  assign out_valid = v3;
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_complex_twiddle_mult_pipe.sv
// tb_complex_twiddle_mult_pipe
//   Directed and randomized checks of complex_twiddle_mult_pipe against a
//   real-arithmetic reference model and an expected-sample queue.
module tb_complex_twiddle_mult_pipe;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam int N  = 64;
  localparam int KW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] in_data;
  logic [KW-1:0]   in_k;
  logic            in_conj;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_data;
  logic            out_ovf;

  complex_twiddle_mult_pipe #(.DW(DW), .TW(TW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
`ifdef TWIDDLE_CONJ_EN
    .in_conj   (in_conj),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*DW-1:0] data;
    logic            ovf;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;
  bit   accepted = 1'b0;
  logic last_in_ready;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: ideal twiddle rounded to Q2.(TW-2), exact products, round, clamp
  function automatic longint rnd_real(input real x);
    return longint'($rtoi($floor(x + 0.5)));
  endfunction

  function automatic longint clamp(input longint v, output bit hit);
    longint hi = (longint'(1) <<< (DW - 1)) - 1;
    longint lo = -(longint'(1) <<< (DW - 1));
    hit = 1'b0;
    if (v > hi) begin hit = 1'b1; return hi; end
    if (v < lo) begin hit = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model(input logic [2*DW-1:0] d, input int k, input bit cj,
                       output logic [2*DW-1:0] od, output logic ov);
    real    ang, one;
    longint a, b, c, s, re, im;
    bit     h1, h2;
    one = 2.0 ** (TW - 2);
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    c   = rnd_real($cos(ang) * one);
    s   = rnd_real($sin(ang) * one);
    if (cj) s = -s;
    a   = longint'($signed(d[2*DW-1:DW]));
    b   = longint'($signed(d[DW-1:0]));
    re  = (a * c + b * s + (longint'(1) <<< (TW - 3))) >>> (TW - 2);
    im  = (b * c - a * s + (longint'(1) <<< (TW - 3))) >>> (TW - 2);
    re  = clamp(re, h1);
    im  = clamp(im, h2);
    od  = {DW'(re), DW'(im)};
    ov  = h1 | h2;
  endtask

  // One cycle: sample after drive, score outputs/inputs, advance to next negedge
  task automatic step();
    #1;
    last_in_ready = in_ready;
    accepted = 1'b0;
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_ovf", out_ovf, exp_q[0].ovf);
          if (out_ready) begin
            if (lat_chk) chk("latency", cyc - exp_q[0].cyc, 3);
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        cur_exp.cyc = cyc;
        exp_q.push_back(cur_exp);
        accepted = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_sample(input logic [2*DW-1:0] d, input int k, input bit cj);
    in_data = d;
    in_k    = KW'(k);
    in_conj = cj;
    model(d, k, cj, cur_exp.data, cur_exp.ovf);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic send_one(input logic [2*DW-1:0] d, input int k, input bit cj,
                          input logic [2*DW-1:0] ed, input logic eo);
    int i;
    in_data      = d;
    in_k         = KW'(k);
    in_conj      = cj;
    cur_exp.data = ed;
    cur_exp.ovf  = eo;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    i = 0;
    do begin step(); i++; end while (!accepted && i < 20);
    if (!accepted) chk("accept_timeout", 0, 1);
    drain();
  endtask

  function automatic logic [DW-1:0] rand_comp();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(DW-1){1'b0}}};
      1:       return {1'b0, {(DW-1){1'b1}}};
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    int idx, n0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_k = '0; in_conj = 1'b0;
    cur_exp = '{data: '0, ovf: 1'b0, cyc: 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed values with latency check
    lat_chk = 1'b1;
    send_one({16'sd1000, -16'sd2000}, 0, 1'b0, {16'sd1000, -16'sd2000}, 1'b0);
    send_one({16'sd16384, 16'sd0}, 8, 1'b0, {16'sd11585, -16'sd11585}, 1'b0);
    send_one({-16'sd32768, 16'sd5}, 16, 1'b0, {16'sd5, 16'sd32767}, 1'b1);
`ifdef TWIDDLE_CONJ_EN
    send_one({16'sd16384, 16'sd0}, 8, 1'b1, {16'sd11585, 16'sd11585}, 1'b0);
`endif
    lat_chk = 1'b0;

    // Back-pressure: 6 samples, downstream stalled for cycles 2..7
    idx = 0; n0 = n_out;
    for (int c = 0; c < 40 && !(idx == 6 && exp_q.size() == 0); c++) begin
      if (idx < 6) begin
        in_valid = 1'b1;
        set_sample({DW'(100 * idx + 7), DW'(-50 * idx)}, 5 * idx + 3, 1'b0);
      end else in_valid = 1'b0;
      out_ready = !(c >= 2 && c <= 7);
      step();
      if (c == 2) chk("in_ready_c2", last_in_ready, 1);
      if (c >= 3 && c <= 7) chk("in_ready_full", last_in_ready, 0);
      if (accepted) idx++;
    end
    chk("bp_count", n_out - n0, 6);
    drain();

    // Reset with two samples in flight
    in_valid = 1'b1; out_ready = 1'b1;
    set_sample({16'sd1234, 16'sd4321}, 9, 1'b0);
    step();
    set_sample({-16'sd77, 16'sd88}, 40, 1'b0);
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 0);
    @(negedge clk);
    repeat (8) step();

    // Randomized traffic
    in_valid = 1'b0; accepted = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 9) < 7);
        if (in_valid) begin
`ifdef TWIDDLE_CONJ_EN
          set_sample({rand_comp(), rand_comp()}, int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)));
`else
          set_sample({rand_comp(), rand_comp()}, int'($urandom_range(0, N - 1)), 1'b0);
`endif
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
